// File: rtl/bsg_fsb_pkg.sv
// Shared field widths and command opcodes for test-node ring packets.
// Packet layout, MSB first: {destid, cmd, payload}.
package bsg_fsb_pkg;

  localparam int fsb_id_width_gp  = 4;
  localparam int fsb_cmd_width_gp = 1;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_REPORT = 2'd1,
    OP_BURST  = 2'd2,
    OP_NOP    = 2'd3
  } fsb_op_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO. ready_o and v_o come straight from the occupancy register,
// so neither has a combinational path from the opposite handshake.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] mem_q, mem_d;
  logic                    wptr_q, wptr_d;
  logic                    rptr_q, rptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    enq, deq;

  assign ready_o = (cnt_q != 2'd2);
  assign v_o     = (cnt_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ~wptr_q;
    end
    if (deq) rptr_d = ~rptr_q;
    cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; cnt_q qualifies every read.
  always_ff @(posedge clk_i) mem_q <= mem_d;

endmodule

// File: rtl/bsg_test_node_client.sv
// Ring test client: echoes data packets (+1), counts them, and serves
// clear/report/burst commands. Responses queue in a two-entry FIFO.
module bsg_test_node_client
  import bsg_fsb_pkg::*;
#(
  parameter ring_width_p = "inv",
  parameter master_id_p  = "inv",
  parameter client_id_p  = "inv"
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic                    error_o,
  output logic [15:0]             count_o
);

  localparam int pw_lp = ring_width_p - fsb_id_width_gp - fsb_cmd_width_gp;

  typedef enum logic {IDLE, BURST} state_e;

  state_e                      state_q, state_d;
  logic [7:0]                  burst_cnt_q, burst_cnt_d;
  logic [7:0]                  burst_n_q, burst_n_d;
  logic [15:0]                 count_q, count_d;
  logic                        error_q, error_d;

  logic [fsb_id_width_gp-1:0]  in_dest;
  logic                        in_cmd;
  logic [pw_lp-1:0]            in_pay;
  logic                        accept;
  logic                        fifo_ready;
  logic                        enq_v;
  logic                        enq_cmd;
  logic [pw_lp-1:0]            enq_pay;

  assign in_dest = data_i[ring_width_p-1 -: fsb_id_width_gp];
  assign in_cmd  = data_i[pw_lp];
  assign in_pay  = data_i[pw_lp-1:0];

  // fifo_ready is a flop output, so ready_o never depends on yumi_i.
  assign ready_o = ~reset_i & en_i & fifo_ready & (state_q == IDLE);
  assign accept  = v_i & ready_o;
  assign error_o = error_q;
  assign count_o = count_q;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    burst_n_d   = burst_n_q;
    count_d     = count_q;
    error_d     = error_q;
    enq_v       = 1'b0;
    enq_cmd     = in_cmd;
    enq_pay     = in_pay + 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_dest != 4'(client_id_p)) begin
            error_d = 1'b1;
          end else if (!in_cmd) begin
            enq_v = 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end else begin
            case (fsb_op_e'(in_pay[1:0]))
              OP_CLEAR:  count_d = 16'd0;
              OP_REPORT: begin
                enq_v   = 1'b1;
                enq_pay = pw_lp'(count_q);
              end
              OP_BURST: begin
                if (in_pay[9:2] != 8'd0) begin
                  burst_n_d   = in_pay[9:2];
                  burst_cnt_d = 8'd0;
                  state_d     = BURST;
                end
              end
              default: ;
            endcase
          end
        end
      end
      BURST: begin
        if (fifo_ready) begin
          enq_v       = 1'b1;
          enq_cmd     = 1'b1;
          enq_pay     = pw_lp'(burst_cnt_q);
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (burst_cnt_q == burst_n_q - 8'd1) begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      burst_cnt_q <= 8'd0;
      burst_n_q   <= 8'd0;
      count_q     <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      burst_n_q   <= burst_n_d;
      count_q     <= count_d;
      error_q     <= error_d;
    end
  end

  bsg_two_fifo #(.width_p(ring_width_p)) out_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (fifo_ready),
    .v_i     (enq_v),
    .data_i  ({4'(master_id_p), enq_cmd, enq_pay}),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

endmodule

// File: doc/bsg_test_node_client.md
BSG_TEST_NODE_CLIENT -- requirements
Module: bsg_test_node_client

Interface
REQ-001 SHALL have parameter ring_width_p, default "inv", ring packet width in bits; legal values are 16 to 80.
REQ-002 SHALL have parameter master_id_p, default "inv", 4-bit node id used as destid on all responses.
REQ-003 SHALL have parameter client_id_p, default "inv", 4-bit node id this block answers to.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit: when low, ready_o=0 and no new packet is accepted.
REQ-007 SHALL have port v_i, input, 1 bit: inbound packet valid.
REQ-008 SHALL have port data_i, input, ring_width_p bits: inbound packet.
REQ-009 SHALL have port ready_o, output, 1 bit: inbound transfer occurs when v_i & ready_o.
REQ-010 SHALL have port v_o, output, 1 bit: response valid.
REQ-011 SHALL have port data_o, output, ring_width_p bits: response packet.
REQ-012 SHALL have port yumi_i, input, 1 bit: consumer takes data_o this cycle; only legal when v_o=1.
REQ-013 SHALL have port error_o, output, 1 bit: sticky flag set by a misaddressed packet.
REQ-014 SHALL have port count_o, output, 16 bits: number of data packets accepted.

Function
REQ-015 Packet layout SHALL be: destid = bits [ring_width_p-1 -: 4], cmd = bit [ring_width_p-5], payload = bits [ring_width_p-6:0].
REQ-016 Response packets SHALL use destid = master_id_p and copy cmd from the request.
REQ-017 A data packet (cmd=0) with destid = client_id_p SHALL enqueue one response whose payload is the request payload + 1, wrapping modulo 2^(ring_width_p-5).
REQ-018 Each accepted data packet SHALL increment count_o; the increment SHALL saturate at 16'hFFFF.
REQ-019 A command packet (cmd=1) SHALL decode its opcode from payload[1:0].
REQ-020 Opcode 0 (clear) SHALL zero count_o; no response is sent.
REQ-021 Opcode 1 (report) SHALL enqueue one response whose payload is count_o, zero-extended.
REQ-022 Opcode 2 (burst) SHALL load N = payload[9:2] and enqueue N responses with payloads 0, 1, ..., N-1 (cmd=1); N=0 produces no responses.
REQ-023 Opcode 3 SHALL be ignored: no response, no error.
REQ-024 A packet whose destid != client_id_p SHALL be consumed and dropped, and SHALL set error_o; it produces no response.
REQ-025 FSM states SHALL be IDLE and BURST.
REQ-026 IDLE -> BURST on acceptance of a burst command with N>0.
REQ-027 BURST -> IDLE when the response with payload N-1 is enqueued.
REQ-028 In BURST, ready_o SHALL be 0, and one response SHALL be enqueued per cycle in which the output buffer is not full.
REQ-029 In IDLE, ready_o SHALL equal en_i & (output buffer not full), which gives a registered-only ready path.
REQ-030 The output buffer SHALL hold 2 entries.
REQ-031 v_o SHALL equal "buffer not empty"; data_o SHALL be the head entry.
REQ-032 Minimum latency SHALL be 1 cycle from an accepted request to the response appearing on v_o.
REQ-033 When the buffer is full, ready_o SHALL be 0 even if yumi_i=1 in the same cycle; no combinational path from yumi_i to ready_o SHALL exist.
REQ-034 Simultaneous enqueue and dequeue with the buffer non-full SHALL preserve order and occupancy.

Reset
REQ-035 On reset_i=1 at a clock edge, the following SHALL occur: state=IDLE, buffer empty, v_o=0, ready_o=0 during reset, error_o=0, count_o=0, burst counter=0.
REQ-036 Reset asserted mid-burst SHALL abort the burst; no further burst responses are emitted.

Structure
REQ-037 Field widths (4-bit id, 1-bit cmd) and opcode constants SHALL live in bsg_fsb_pkg.
REQ-038 FSM state enum SHALL be local to the module.
REQ-039 The output buffer SHALL be one instance of bsg_two_fifo (width ring_width_p).

Verification (ring_width_p=80, master_id_p=0, client_id_p=1)
REQ-040 Data packet, destid=1, payload=5, yumi_i held 1 -> one response, destid=0, payload=6, v_o 1 cycle after accept; count_o=1.
REQ-041 Data packet with payload all-ones -> response payload 0 (wrap).
REQ-042 Burst opcode with N=4 and yumi_i low for 3 cycles, then high -> ready_o=0 throughout; payloads 0,1,2,3 delivered in order; return to IDLE; ready_o=1 afterwards.
REQ-043 Packet with destid=3 -> no response; error_o=1 and remains 1 until reset.
REQ-044 Three data packets, report command, clear command, report command -> responses payload 4,5,6, then 3, then 0.
REQ-045 reset_i pulsed after 2 of 10 burst responses -> v_o=0 the next cycle; no further responses; count_o=0.
